// File: rtl/dense_layer.sv
// Sequential fully-connected layer: one multiply-accumulate per cycle against a 2-cycle-latency weight RAM.
// Define DENSE_LAYER_RELU_EN to clamp negative results to zero before saturation.
module dense_layer #(
  parameter int INPUT_SIZE  = 784,
  parameter int OUTPUT_SIZE = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int SHIFT       = 7,
  localparam int ADDR_WIDTH = (INPUT_SIZE * OUTPUT_SIZE > 1) ? $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  output logic                                        done,
  input  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]       layer_in,
  output logic                                        weights_read_en,
  output logic [ADDR_WIDTH-1:0]                       weights_read_address,
  input  logic signed [DATA_WIDTH-1:0]                weights,
  input  logic [OUTPUT_SIZE-1:0][ACC_WIDTH-1:0]       biases,
  output logic [OUTPUT_SIZE-1:0][DATA_WIDTH-1:0]      layer_out
);

  localparam int IDX_WIDTH = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int NEU_WIDTH = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(INPUT_SIZE - 1);
  localparam logic [NEU_WIDTH-1:0] LAST_NEU = NEU_WIDTH'(OUTPUT_SIZE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  logic [2:0]                  state;
  logic [NEU_WIDTH-1:0]        n;
  logic [IDX_WIDTH-1:0]        i;
  logic                        drain_second;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [1:0]                  valid_pipe;
  logic [IDX_WIDTH-1:0]        idx_d1;
  logic [IDX_WIDTH-1:0]        idx_d2;

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext;
  logic signed [ACC_WIDTH-1:0]    biased;
  logic signed [ACC_WIDTH-1:0]    shifted;
  logic signed [ACC_WIDTH-1:0]    relu_v;
  logic [DATA_WIDTH-1:0]          sat_v;

  // idx_d2 names the activation that pairs with the weight arriving this cycle
  assign product     = weights * $signed(layer_in[idx_d2]);
  assign product_ext = ACC_WIDTH'(product);

  always_comb begin
    biased  = acc + $signed(biases[n]);
    shifted = biased >>> SHIFT;
  end

`ifdef DENSE_LAYER_RELU_EN
  assign relu_v = shifted[ACC_WIDTH-1] ? '0 : shifted;
`else
  assign relu_v = shifted;
`endif

  always_comb begin
    if (relu_v > OUT_MAX)
      sat_v = OUT_MAX[DATA_WIDTH-1:0];
    else if (relu_v < OUT_MIN)
      sat_v = OUT_MIN[DATA_WIDTH-1:0];
    else
      sat_v = relu_v[DATA_WIDTH-1:0];
  end

  // Read outputs are registered, so the address seen in a cycle belongs to index i of that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      n                    <= '0;
      i                    <= '0;
      drain_second         <= 1'b0;
      acc                  <= '0;
      valid_pipe           <= '0;
      idx_d1               <= '0;
      idx_d2               <= '0;
      done                 <= 1'b0;
      weights_read_en      <= 1'b0;
      weights_read_address <= '0;
      layer_out            <= '0;
    end else begin
      valid_pipe <= {valid_pipe[0], weights_read_en};
      idx_d1     <= i;
      idx_d2     <= idx_d1;
      if (valid_pipe[1])
        acc <= acc + product_ext;

      case (state)
        S_IDLE: begin
          done            <= 1'b0;
          weights_read_en <= 1'b0;
          n               <= '0;
          i               <= '0;
          if (start) begin
            state                <= S_ISSUE;
            acc                  <= '0;
            weights_read_en      <= 1'b1;
            weights_read_address <= '0;
          end
        end
        S_ISSUE: begin
          if (i == LAST_IDX) begin
            state           <= S_DRAIN;
            weights_read_en <= 1'b0;
            drain_second    <= 1'b0;
          end else begin
            i                    <= i + 1'b1;
            weights_read_address <= weights_read_address + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_second)
            state <= S_FINISH;
          else
            drain_second <= 1'b1;
        end
        S_FINISH: begin
          layer_out[n] <= sat_v;
          if (n == LAST_NEU) begin
            state <= S_DONE;
          end else begin
            state                <= S_ISSUE;
            n                    <= n + 1'b1;
            i                    <= '0;
            acc                  <= '0;
            weights_read_en      <= 1'b1;
            weights_read_address <= weights_read_address + 1'b1;
          end
        end
        S_DONE: begin
          weights_read_en <= 1'b0;
          // done is held off until start drops, so a held start cannot launch a second pass
          if (!start) begin
            state                <= S_IDLE;
            done                 <= 1'b0;
            n                    <= '0;
            i                    <= '0;
            weights_read_address <= '0;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer (4 inputs, 2 neurons) with a 2-cycle weight RAM model.
// A second instance with SHIFT=1 shares the RAM and inputs to check floor rounding.
module tb_dense_layer;

  localparam int IN  = 4;
  localparam int OUT = 2;
  localparam int DW  = 8;
  localparam int AW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     start;
  logic [IN-1:0][DW-1:0]    layer_in;
  logic [OUT-1:0][AW-1:0]   biases;
  logic signed [DW-1:0]     weights;
  logic                     done0, en0, done1, en1;
  logic [2:0]               addr0, addr1;
  logic [OUT-1:0][DW-1:0]   out0, out1;

  dense_layer #(.INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done0), .layer_in(layer_in),
    .weights_read_en(en0), .weights_read_address(addr0), .weights(weights),
    .biases(biases), .layer_out(out0)
  );

  dense_layer #(.INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT(1)) dut_shift (
    .clk(clk), .rst(rst), .start(start), .done(done1), .layer_in(layer_in),
    .weights_read_en(en1), .weights_read_address(addr1), .weights(weights),
    .biases(biases), .layer_out(out1)
  );

  // Weight RAM: address presented in cycle c yields data during cycle c+2
  logic [DW-1:0] mem [IN*OUT];
  logic [DW-1:0] ram_q1;
  always @(posedge clk) begin
    ram_q1  <= mem[addr0];
    weights <= ram_q1;
  end

  typedef struct packed {
    logic [IN-1:0][DW-1:0]     act;
    logic [IN*OUT-1:0][DW-1:0] w;
    logic [OUT-1:0][AW-1:0]    b;
    logic [OUT-1:0][DW-1:0]    exp0;
    logic [OUT-1:0][DW-1:0]    exp1;
  } vec_t;

  vec_t vecs [6];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [DW-1:0] rl(input logic [DW-1:0] v);
`ifdef DENSE_LAYER_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int k);
    layer_in = vecs[k].act;
    biases   = vecs[k].b;
    for (int j = 0; j < IN*OUT; j++) mem[j] = vecs[k].w[j];
  endtask

  task automatic checkResults(input string tag, input int k);
    for (int j = 0; j < OUT; j++) begin
      checkOutput($sformatf("%s out[%0d]", tag, j), 32'(out0[j]), 32'(rl(vecs[k].exp0[j])));
      checkOutput($sformatf("%s shift1 out[%0d]", tag, j), 32'(out1[j]), 32'(rl(vecs[k].exp1[j])));
    end
  endtask

  // Raises start, counts edges from the one that samples it, and checks timing and address order
  task automatic runPass(input string tag, input bit glitch);
    int done_cycle;
    int naddr;
    int bad;
    start      = 1'b1;
    done_cycle = -1;
    naddr      = 0;
    bad        = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (en1 !== en0 || addr1 !== addr0) bad++;
      if (en0) begin
        if (addr0 !== 3'(naddr)) bad++;
        naddr++;
      end
      if (glitch && c == 2) start = 1'b0;
      if (glitch && c == 3) start = 1'b1;
      if (done0) begin
        done_cycle = c;
        break;
      end
    end
    checkOutput({tag, " done cycle"}, 32'(done_cycle), 32'd15);
    checkOutput({tag, " read count"}, 32'(naddr), 32'd8);
    checkOutput({tag, " address sequence errors"}, 32'(bad), 32'd0);
    checkOutput({tag, " shift1 done"}, 32'(done1), 32'd1);
  endtask

  task automatic releaseStart(input string tag);
    int en_seen;
    en_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (en0) en_seen++;
    end
    checkOutput({tag, " done held"}, 32'(done0), 32'd1);
    checkOutput({tag, " no reads while done"}, 32'(en_seen), 32'd0);
    start = 1'b0;
    @(negedge clk);
    checkOutput({tag, " done cleared"}, 32'(done0), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    layer_in = '0;
    biases   = '0;
    for (int j = 0; j < IN*OUT; j++) mem[j] = '0;

    vecs[0].act  = {8'd4, 8'd3, 8'd2, 8'd1};
    vecs[0].w    = {8{8'd1}};
    vecs[0].b    = {32'd5, 32'd0};
    vecs[0].exp0 = {8'd15, 8'd10};
    vecs[0].exp1 = {8'd7, 8'd5};

    vecs[1].act  = {4{8'd127}};
    vecs[1].w    = {8{8'd127}};
    vecs[1].b    = '0;
    vecs[1].exp0 = {8'd127, 8'd127};
    vecs[1].exp1 = {8'd127, 8'd127};

    vecs[2].act  = {4{8'd127}};
    vecs[2].w    = {8{8'h80}};
    vecs[2].b    = '0;
    vecs[2].exp0 = {8'h80, 8'h80};
    vecs[2].exp1 = {8'h80, 8'h80};

    vecs[3].act  = {8'd0, 8'd0, 8'd0, 8'd1};
    vecs[3].w    = {{4{8'd1}}, {4{8'hFD}}};
    vecs[3].b    = {32'd4, 32'd0};
    vecs[3].exp0 = {8'd5, 8'hFD};
    vecs[3].exp1 = {8'd2, 8'hFE};

    vecs[4].act  = {8'd3, 8'd0, 8'd5, 8'hFE};
    vecs[4].w    = {8'hFE, 8'd1, 8'd2, 8'hFC, 8'd2, 8'd7, 8'hFF, 8'd3};
    vecs[4].b    = {32'd116, 32'hFFFF_FFFF};
    vecs[4].exp0 = {8'd127, 8'hFA};
    vecs[4].exp1 = {8'd64, 8'hFD};

    vecs[5].act  = {8'd0, 8'd0, 8'd0, 8'd1};
    vecs[5].w    = {{4{8'd0}}, {4{8'd1}}};
    vecs[5].b    = {32'hFFFF_FF7F, 32'h7FFF_FFFF};
    vecs[5].exp0 = {8'h80, 8'h80};
    vecs[5].exp1 = {8'hBF, 8'h80};

    repeat (2) @(negedge clk);
    checkOutput("reset done", 32'(done0), 32'd0);
    checkOutput("reset read_en", 32'(en0), 32'd0);
    checkOutput("reset address", 32'(addr0), 32'd0);
    checkOutput("reset layer_out", 32'(out0), 32'd0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle read_en", 32'(en0), 32'd0);
    checkOutput("idle done", 32'(done0), 32'd0);

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      applyStimulus(k);
      runPass($sformatf("vec%0d", k), 1'b0);
      checkResults($sformatf("vec%0d", k), k);
      releaseStart($sformatf("vec%0d", k));
    end

    // Start held through done, dropped for one cycle, then raised: exactly one more pass
    @(negedge clk);
    applyStimulus(0);
    runPass("rearm first", 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    runPass("rearm second", 1'b0);
    checkResults("rearm second", 0);
    releaseStart("rearm second");

    // A start glitch in the middle of ISSUE must not disturb the pass
    @(negedge clk);
    applyStimulus(4);
    runPass("glitch", 1'b1);
    checkResults("glitch", 4);
    releaseStart("glitch");

    // Reset during the second neuron's ISSUE, then a new pass straight after release
    @(negedge clk);
    applyStimulus(0);
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 3)
        checkOutput("hold across passes out[1]", 32'(out0[1]), 32'(rl(vecs[4].exp0[1])));
    end
    checkOutput("mid-pass out[0] written", 32'(out0[0]), 32'(rl(vecs[0].exp0[0])));
    rst = 1'b1;
    #1;
    checkOutput("mid-pass reset done", 32'(done0), 32'd0);
    checkOutput("mid-pass reset layer_out", 32'(out0), 32'd0);
    checkOutput("mid-pass reset read_en", 32'(en0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runPass("after reset", 1'b0);
    checkResults("after reset", 0);
    releaseStart("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_layer.md
DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 Parameters (name, default, meaning): INPUT_SIZE, 784, activations per input vector.
REQ-002 OUTPUT_SIZE, 10, neurons in this layer.
REQ-003 DATA_WIDTH, 8, signed activation and weight width.
REQ-004 ACC_WIDTH, 32, signed accumulator and bias width.
REQ-005 SHIFT, 7, arithmetic right shift applied to the biased accumulator before output.
REQ-006 Ports (name direction width meaning). clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 start  in  1  level request to run one layer pass.
REQ-009 done  out  1  pass complete; stays high while start stays high.
REQ-010 layer_in  in  DATA_WIDTH x INPUT_SIZE  signed input activations; must be held stable from start until done.
REQ-011 weights_read_en  out  1  weight RAM read enable.
REQ-012 weights_read_address  out  $clog2(INPUT_SIZE*OUTPUT_SIZE)  weight index, equal to n*INPUT_SIZE+i.
REQ-013 weights  in  DATA_WIDTH  signed weight data, valid exactly 2 cycles after its address/enable are presented.
REQ-014 biases  in  ACC_WIDTH x OUTPUT_SIZE  signed per-neuron bias.
REQ-015 layer_out  out  DATA_WIDTH x OUTPUT_SIZE  signed registered results.

Function
REQ-016 States shall be IDLE, ISSUE, DRAIN, FINISH and DONE.
REQ-017 IDLE: done=0, weights_read_en=0, n=0, i=0; start=1 sampled -> ISSUE.
REQ-018 ISSUE: one weight read per cycle, en=1, address n*INPUT_SIZE+i, i++; after i=INPUT_SIZE-1 -> DRAIN.
REQ-019 A 2-deep valid/index shift register shall track each issued read; when weights returns, acc += weights * layer_in[tracked index], using a full-precision signed product sign-extended to ACC_WIDTH.
REQ-020 acc shall clear to 0 on entry to ISSUE for each neuron.
REQ-021 DRAIN shall last exactly 2 cycles with en=0, absorbing the last two returns, then -> FINISH.
REQ-022 FINISH: compute v=(acc+biases[n])>>>SHIFT (floor), saturate v to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], write layer_out[n]; if n==OUTPUT_SIZE-1 -> DONE, else n++, i=0 -> ISSUE.
REQ-023 Per-neuron latency shall be INPUT_SIZE+3 cycles; done shall first read 1 exactly 1+OUTPUT_SIZE*(INPUT_SIZE+3) cycles after the edge that samples start in IDLE.
REQ-024 DONE: done=1, en=0; start=0 -> IDLE. done shall not re-arm until start has been low for at least one cycle.
REQ-025 start changes outside IDLE and DONE shall be ignored (no abort, no restart).
REQ-026 Accumulator overflow wraps modulo 2^ACC_WIDTH; only the final output saturates.
REQ-027 layer_out[k] shall change only in FINISH for neuron k and otherwise hold its value, including across passes.

Reset
REQ-028 rst=1 shall immediately force state IDLE, n=0, i=0, acc=0, clear the valid pipeline, and set done=0, weights_read_en=0, weights_read_address=0 and all layer_out entries to 0.
REQ-029 rst asserted mid-pass shall discard the pass; weight data returned after rst deasserts shall not be accumulated.
REQ-030 After rst deasserts, the block shall sit in IDLE until start is sampled high.

Configuration
REQ-031 Macro DENSE_LAYER_RELU_EN: when defined, FINISH shall clamp negative v to 0 before saturation, so outputs lie in [0, 2^(DATA_WIDTH-1)-1].
REQ-032 When DENSE_LAYER_RELU_EN is undefined, outputs pass signed with saturation only; latency is identical in both builds.

Verification
REQ-033 Bench parameters INPUT_SIZE=4, OUTPUT_SIZE=2, SHIFT=0, with a 2-cycle-latency RAM model.
REQ-034 Scenario: layer_in={1,2,3,4}, all weights=1, biases={0,5}, start held -> layer_out={10,15}; done high at cycle 1+2*7=15; address sequence 0..7.
REQ-035 Scenario: weights=127, layer_in all 127, bias 0 -> both outputs saturate to 127; with all weights=-128 -> -128 without RELU_EN, 0 with RELU_EN.
REQ-036 Scenario: rst pulsed while the neuron-1 ISSUE is in progress -> done=0, layer_out={0,0} immediately; a fresh start then gives the correct results with correct timing.
REQ-037 Scenario: start held after done, then toggled low for 1 cycle and high again -> exactly one additional pass; start pulsed during ISSUE -> no effect on timing or results.
REQ-038 Scenario: SHIFT=1, acc+bias=-3 -> output -2 (floor), without RELU_EN.
